// File: rtl/controle_exibicao.sv
// Sequenced LED display controller: walks memory addresses 0..limite, lighting
// each word for T_ON cycles followed by T_OFF dark cycles, then pulses pronto.
module controle_exibicao #(
    parameter int unsigned T_ON  = 25_000_000,
    parameter int unsigned T_OFF = 12_500_000
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic       iniciar_i,
    input  logic       cancela_i,
    input  logic [3:0] limite_i,
    input  logic [3:0] dado_i,
    output logic [3:0] endereco_o,
    output logic [3:0] leds_o,
    output logic       ocupado_o,
    output logic       pronto_o,
    output logic [3:0] db_estado_o
);

    localparam int unsigned TW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned SW = 3;

    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] PREPARA = 3'd1;
    localparam logic [2:0] ACENDE  = 3'd2;
    localparam logic [2:0] APAGA   = 3'd3;
    localparam logic [2:0] FIM     = 3'd4;

    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

    logic [SW-1:0] state_q,    state_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [AW-1:0] endereco_q, endereco_d;
    logic [AW-1:0] limite_q,   limite_d;
    logic          ocupado_q,  ocupado_d;
    logic          pronto_q,   pronto_d;

    // State, timer, address and captured limit registers
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= OCIOSO;
            timer_q    <= '0;
            endereco_q <= '0;
            limite_q   <= '0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    // Next-state logic; cancela overrides every other transition
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        ocupado_d  = 1'b0;
        pronto_d   = 1'b0;

        case (state_q)
            OCIOSO: begin
                if (iniciar_i && !cancela_i) begin
                    state_d = PREPARA;
                end
            end
            PREPARA: begin
                endereco_d = '0;
                timer_d    = '0;
                limite_d   = limite_i;
                state_d    = ACENDE;
            end
            ACENDE: begin
                if (timer_q == ON_LAST) begin
                    timer_d = '0;
                    state_d = APAGA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            APAGA: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    if (endereco_q == limite_q) begin
                        state_d = FIM;
                    end else begin
                        endereco_d = endereco_q + AW'(1);
                        state_d    = ACENDE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FIM: begin
                state_d = OCIOSO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase

        if (cancela_i && (state_q != OCIOSO)) begin
            state_d    = OCIOSO;
            endereco_d = '0;
            timer_d    = '0;
        end

        // Status flags registered alongside the state they describe
        ocupado_d = (state_d == PREPARA) || (state_d == ACENDE) || (state_d == APAGA);
        pronto_d  = (state_d == FIM);
    end

    assign endereco_o  = endereco_q;
    assign ocupado_o   = ocupado_q;
    assign pronto_o    = pronto_q;
    assign db_estado_o = {1'b0, state_q};
    // LEDs follow the memory word combinationally, only while lit
    assign leds_o      = (state_q == ACENDE) ? dado_i : 4'b0000;

endmodule

// File: tb/tb_controle_exibicao.sv
// Directed table-driven bench for controle_exibicao with T_ON=3, T_OFF=2.
module tb_controle_exibicao;

    logic       clk;
    logic       rst_n;
    logic       iniciar;
    logic       cancela;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       ini;
        logic       can;
        logic [3:0] lim;
        logic [3:0] st;
        logic [3:0] addr;
        logic [3:0] leds;
        logic       oc;
        logic       pr;
    } vec_t;

    vec_t vq[$];

    controle_exibicao #(.T_ON(3), .T_OFF(2)) dut (
        .clock_i    (clk),
        .reset_ni   (rst_n),
        .iniciar_i  (iniciar),
        .cancela_i  (cancela),
        .limite_i   (limite),
        .dado_i     (dado),
        .endereco_o (endereco),
        .leds_o     (leds),
        .ocupado_o  (ocupado),
        .pronto_o   (pronto),
        .db_estado_o(db_estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model answers the address combinationally
    always_comb dado = mem[endereco];

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic push(input logic ini, input logic can, input logic [3:0] lim, input logic [3:0] st,
                        input logic [3:0] addr, input logic [3:0] ld, input logic oc, input logic pr);
        vec_t v;
        v.ini = ini; v.can = can; v.lim = lim; v.st = st;
        v.addr = addr; v.leds = ld; v.oc = oc; v.pr = pr;
        vq.push_back(v);
    endtask

    // Expected trace of one full run: cycle 0 is the OCIOSO cycle sampling iniciar
    task automatic build_run(input logic [3:0] lim, input logic [3:0] prev_addr, input logic ini_hold);
        push(1'b1, 1'b0, lim, 4'd0, prev_addr, 4'h0, 1'b0, 1'b0);
        push(ini_hold, 1'b0, lim, 4'd1, prev_addr, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i <= int'(lim); i++) begin
            for (int t = 0; t < 3; t++) push(ini_hold, 1'b0, lim, 4'd2, 4'(i), mem[4'(i)], 1'b1, 1'b0);
            for (int t = 0; t < 2; t++) push(ini_hold, 1'b0, lim, 4'd3, 4'(i), 4'h0, 1'b1, 1'b0);
        end
        push(ini_hold, 1'b0, lim, 4'd4, lim, 4'h0, 1'b0, 1'b1);
        push(ini_hold, 1'b0, lim, 4'd0, lim, 4'h0, 1'b0, 1'b0);
    endtask

    // Apply each row at mid-cycle, compare outputs, advance one clock
    task automatic apply_table(input string tag);
        for (int r = 0; r < vq.size(); r++) begin
            iniciar = vq[r].ini;
            cancela = vq[r].can;
            limite  = vq[r].lim;
            #1;
            check({tag, ".estado"},   r, 32'(db_estado), 32'(vq[r].st));
            check({tag, ".endereco"}, r, 32'(endereco),  32'(vq[r].addr));
            check({tag, ".leds"},     r, 32'(leds),      32'(vq[r].leds));
            check({tag, ".ocupado"},  r, 32'(ocupado),   32'(vq[r].oc));
            check({tag, ".pronto"},   r, 32'(pronto),    32'(vq[r].pr));
            @(negedge clk);
        end
        vq.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".estado"},   0, 32'(db_estado), 32'd0);
        check({tag, ".endereco"}, 0, 32'(endereco),  32'd0);
        check({tag, ".leds"},     0, 32'(leds),      32'd0);
        check({tag, ".ocupado"},  0, 32'(ocupado),   32'd0);
        check({tag, ".pronto"},   0, 32'(pronto),    32'd0);
    endtask

    task automatic load_mem_axc();
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        mem[0] = 4'hA;
        mem[1] = 4'h5;
        mem[2] = 4'hC;
    endtask

    initial begin
        rst_n   = 1'b0;
        iniciar = 1'b0;
        cancela = 1'b0;
        limite  = 4'd0;
        load_mem_axc();

        // Reset held across a clock edge
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal run: limite=2, memory {A,5,C}
        build_run(4'd2, 4'd0, 1'b0);
        apply_table("nominal");

        // Abort at cycle 8: OCIOSO from cycle 9, no pronto through cycle 20
        build_run(4'd2, 4'd2, 1'b0);
        while (vq.size() > 9) void'(vq.pop_back());
        vq[8].can = 1'b1;
        for (int i = 9; i <= 20; i++) push(1'b0, 1'b0, 4'd2, 4'd0, 4'd0, 4'h0, 1'b0, 1'b0);
        apply_table("abort");

        // Single element: limite=0, dado=7
        mem[0] = 4'h7;
        build_run(4'd0, 4'd0, 1'b0);
        apply_table("single");

        // iniciar held high, limite changed to 5 from cycle 3; restart captures 5
        load_mem_axc();
        mem[3] = 4'h9;
        build_run(4'd2, 4'd0, 1'b1);
        for (int i = 3; i < vq.size(); i++) vq[i].lim = 4'd5;
        void'(vq.pop_back());
        build_run(4'd5, 4'd2, 1'b1);
        while (vq.size() > 39) void'(vq.pop_back());
        vq[38].can = 1'b1;
        vq[38].ini = 1'b0;
        push(1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 4'h0, 1'b0, 1'b0);
        apply_table("hold");

        // Async reset mid-ACENDE, then a fresh run
        build_run(4'd1, 4'd0, 1'b0);
        while (vq.size() > 4) void'(vq.pop_back());
        apply_table("pre_rst");
        iniciar = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_held");
        rst_n = 1'b1;
        build_run(4'd1, 4'd0, 1'b0);
        apply_table("post_rst");

        // Maximum limite: addresses 0..15, pronto at cycle 82
        for (int i = 0; i < 16; i++) mem[i] = 4'(i) ^ 4'h6;
        build_run(4'd15, 4'd1, 1'b0);
        check("max.pronto_row", 0, 32'(vq[82].pr), 32'd1);
        apply_table("max");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
